// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification helpers for the
// sequential execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_MULHU = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_DIV   = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_REM   = 4'b1010;
  localparam logic [3:0] ALU_REMU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_iter(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: one unsigned shift-add multiply step or one
// restoring-divide step per cycle on a 2*XLEN accumulator.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_step,
  output logic              last
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   sum, rem_s, diff;

  always_comb begin
    hi    = acc_q[2*XLEN-1:XLEN];
    lo    = acc_q[XLEN-1:0];
    sum   = {1'b0, hi} + {1'b0, (lo[0] ? opb_q : {XLEN{1'b0}})};
    rem_s = {hi, lo[XLEN-1]};
    diff  = rem_s - {1'b0, opb_q};
    if (div_q) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else             acc_step = {rem_s[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {sum, lo[XLEN-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      acc_d = {{XLEN{1'b0}}, opa};
      opb_d = opb;
      div_d = div_mode;
      cnt_d = CNT_INIT;
    end else if (step && (cnt_q != '0)) begin
      acc_d = acc_step;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // The FSM leaves BUSY with one step still pending; FIX consumes acc_step.
  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    opb_q <= opb_d;
    div_q <= div_d;
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential EX-stage ALU: single-cycle logic/add ops plus iterative RV-M
// multiply/divide behind a valid/ready handshake.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      op_q, op_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;

  logic signed [XLEN-1:0] a_s, b_s;
  logic                   a_neg, b_neg, is_sdiv, b_zero, ovf, fast_div;
  logic                   accept, start, step, last;
  logic [XLEN-1:0]        opa, opb, fast_res, alu_res, fix_res;
  logic                   alu_ill;
  logic [2*XLEN-1:0]      acc_step;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN:0] alu_single(input logic [3:0] o,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    case (o)
      ALU_AND: return {1'b0, x & y};
      ALU_OR:  return {1'b0, x | y};
      ALU_ADD: return {1'b0, x + y};
      ALU_SUB: return {1'b0, x - y};
      ALU_NOR: return {1'b0, ~x & ~y};
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign a_neg = (a_s < 0);
  assign b_neg = (b_s < 0);

  always_comb begin
    is_sdiv  = (op == ALU_DIV) || (op == ALU_REM);
    b_zero   = (b == '0);
    ovf      = is_sdiv && (a == XMIN) && (b == '1);
    fast_div = is_div_op(op) && (b_zero || ovf);
    if (b_zero) fast_res = ((op == ALU_DIV) || (op == ALU_DIVU)) ? '1 : a;
    else        fast_res = (op == ALU_DIV) ? XMIN : '0;
    // Signed divides iterate on magnitudes; signs are restored in FIX.
    opa = (is_sdiv && a_neg) ? negate(a) : a;
    opb = (is_sdiv && b_neg) ? negate(b) : b;
    {alu_ill, alu_res} = alu_single(op, a, b);
  end

  always_comb begin
    case (op_q)
      ALU_MUL:            fix_res = acc_step[XLEN-1:0];
      ALU_MULHU:          fix_res = acc_step[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:  fix_res = qneg_q ? negate(acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
      default:            fix_res = rneg_q ? negate(acc_step[2*XLEN-1:XLEN])
                                           : acc_step[2*XLEN-1:XLEN];
    endcase
  end

  assign accept = (state_q == ST_IDLE) && in_valid && !flush;
  assign step   = ((state_q == ST_BUSY) || (state_q == ST_FIX)) && !flush;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op;
          qneg_d = (op == ALU_DIV) && (a_neg ^ b_neg);
          rneg_d = (op == ALU_REM) && a_neg;
          if (is_iter(op) && !fast_div) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            result_d  = is_iter(op) ? fast_res : alu_res;
            illegal_d = is_iter(op) ? 1'b0 : alu_ill;
            state_d   = ST_DONE;
          end
        end
      end
      ST_BUSY: if (last) state_d = ST_FIX;
      ST_FIX: begin
        result_d  = fix_res;
        illegal_d = 1'b0;
        state_d   = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      result_d  = result_q;
      illegal_d = illegal_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .start    (start),
    .step     (step),
    .div_mode (is_div_op(op)),
    .opa      (opa),
    .opb      (opb),
    .acc_step (acc_step),
    .last     (last)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = ~|result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomized bench for alu_muldiv_seq at XLEN=64 and XLEN=32,
// checked against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic        iv64 = 1'b0, iv32 = 1'b0;
  logic        ir64, ov64, z64, il64;
  logic [63:0] r64;
  logic        ir32, ov32, z32, il32;
  logic [31:0] r32;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .op(op), .a(a), .b(b), .out_valid(ov64), .out_ready(out_ready),
    .result(r64), .zero(z64), .illegal(il64)
  );

  alu_muldiv_seq #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .op(op), .a(a[31:0]), .b(b[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .zero(z32), .illegal(il32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {iterative, fast_path, illegal, result} from the arithmetic rules.
  function automatic logic [66:0] model(input logic [3:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input int w);
    logic [63:0]  mask, ua, ub, minv, res;
    logic [127:0] prod;
    longint       sa, sb;
    int           t;
    logic         it, fast, ill;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    ua = x & mask;
    ub = y & mask;
    if (w == 64) begin
      sa = longint'(ua);
      sb = longint'(ub);
    end else begin
      t = int'(ua[31:0]); sa = t;
      t = int'(ub[31:0]); sb = t;
    end
    prod = {64'b0, ua} * {64'b0, ub};
    it = 1'b0; fast = 1'b0; ill = 1'b0; res = '0;
    case (o)
      ALU_AND: res = ua & ub;
      ALU_OR:  res = ua | ub;
      ALU_ADD: res = (ua + ub) & mask;
      ALU_SUB: res = (ua - ub) & mask;
      ALU_NOR: res = ~(ua | ub) & mask;
      ALU_MUL: begin it = 1'b1; res = prod[63:0] & mask; end
      ALU_MULHU: begin it = 1'b1; res = 64'(prod >> w) & mask; end
      ALU_DIV, ALU_REM: begin
        it = 1'b1;
        if (ub == 0) begin
          fast = 1'b1; res = (o == ALU_DIV) ? mask : ua;
        end else if (ua == minv && ub == mask) begin
          fast = 1'b1; res = (o == ALU_DIV) ? minv : 64'd0;
        end else begin
          res = 64'((o == ALU_DIV) ? (sa / sb) : (sa % sb)) & mask;
        end
      end
      ALU_DIVU, ALU_REMU: begin
        it = 1'b1;
        if (ub == 0) begin
          fast = 1'b1; res = (o == ALU_DIVU) ? mask : ua;
        end else begin
          res = (o == ALU_DIVU) ? (ua / ub) : (ua % ub);
        end
      end
      default: ill = 1'b1;
    endcase
    return {it, fast, ill, res};
  endfunction

  task automatic issue(input bit s32, input logic [3:0] o, input logic [63:0] x,
                       input logic [63:0] y, output logic [63:0] res,
                       output logic ill, output logic zr, output int lat);
    check("in_ready_before_issue", 64'(s32 ? ir32 : ir64), 64'd1);
    op = o; a = x; b = y;
    if (s32) iv32 = 1'b1; else iv64 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    lat = 1;
    while (!(s32 ? ov32 : ov64) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = s32 ? {32'b0, r32} : r64;
    ill = s32 ? il32 : il64;
    zr  = s32 ? z32 : z64;
  endtask

  task automatic exec(input bit s32, input logic [3:0] o, input logic [63:0] x,
                      input logic [63:0] y, input string tag);
    logic [66:0] m;
    logic [63:0] res;
    logic        ill, zr;
    int          lat, w, exp_lat;
    w = s32 ? 32 : 64;
    m = model(o, x, y, w);
    exp_lat = (m[66] && !m[65]) ? w + 1 : 1;
    issue(s32, o, x, y, res, ill, zr, lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, res, m[63:0]);
    check({tag, "_illegal"}, 64'(ill), 64'(m[64]));
    check({tag, "_zero"}, 64'(zr), 64'(m[63:0] == 64'd0));
    @(posedge clk); #1;
  endtask

  logic [3:0]  ops [11] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_MUL,
                            ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  initial begin
    logic [63:0] res, x, y;
    logic        ill, zr, seen;
    logic [3:0]  o;
    int          lat, idx;
    bit          s32;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(ir64), 64'd1);
    check("reset_out_valid", 64'(ov64), 64'd0);
    check("reset_result", r64, 64'd0);
    check("reset_zero", 64'(z64), 64'd1);
    check("reset_illegal", 64'(il64), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exec(0, ALU_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, "add_cancel");
    check("add_cancel_held", r64, 64'd0);
    exec(0, ALU_NOR, 64'd0, 64'd0, "nor_zero");
    check("nor_zero_held", r64, 64'hFFFF_FFFF_FFFF_FFFF);
    exec(0, ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mul_lo");
    check("mul_lo_held", r64, 64'hFFFF_FFFF_FFFF_FFFE);
    exec(0, ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulhu");
    check("mulhu_held", r64, 64'd1);

    exec(1, ALU_DIV, 64'hFFFF_FFF9, 64'd2, "div32_neg");
    check("div32_neg_held", {32'b0, r32}, 64'hFFFF_FFFD);
    exec(1, ALU_REM, 64'hFFFF_FFF9, 64'd2, "rem32_neg");
    check("rem32_neg_held", {32'b0, r32}, 64'hFFFF_FFFF);
    exec(1, ALU_DIVU, 64'd7, 64'd0, "divu32_by0");
    check("divu32_by0_held", {32'b0, r32}, 64'hFFFF_FFFF);
    exec(1, ALU_REMU, 64'd7, 64'd0, "remu32_by0");
    check("remu32_by0_held", {32'b0, r32}, 64'd7);
    exec(1, ALU_DIV, 64'h8000_0000, 64'hFFFF_FFFF, "div32_ovf");
    check("div32_ovf_held", {32'b0, r32}, 64'h8000_0000);

    out_ready = 1'b0;
    issue(0, ALU_DIVU, 64'd100, 64'd7, res, ill, zr, lat);
    check("stall_result", res, 64'd14);
    check("stall_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 64'(ov64), 64'd1);
      check("stall_hold_result", r64, 64'd14);
      check("stall_in_ready", 64'(ir64), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 64'(ov64), 64'd0);
    check("release_in_ready", 64'(ir64), 64'd1);

    op = ALU_MUL; a = 64'd3; b = 64'd5; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_in_ready", 64'(ir64), 64'd1);
    check("flush_busy_out_valid", 64'(ov64), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (ov64) seen = 1'b1;
    end
    check("flush_busy_never_valid", 64'(seen), 64'd0);
    check("flush_busy_result_kept", r64, 64'd14);

    flush = 1'b1; iv64 = 1'b1; op = ALU_ADD; a = 64'd1; b = 64'd1;
    @(posedge clk); #1;
    flush = 1'b0; iv64 = 1'b0;
    check("flush_accept_in_ready", 64'(ir64), 64'd1);
    check("flush_accept_out_valid", 64'(ov64), 64'd0);
    @(posedge clk); #1;
    check("flush_accept_still_idle", 64'(ov64), 64'd0);
    check("flush_accept_result", r64, 64'd14);

    exec(0, 4'b1111, 64'h1234, 64'h5678, "illegal_1111");
    exec(1, 4'b0101, 64'hAB, 64'hCD, "illegal_0101");
    exec(1, 4'b0111, 64'h1, 64'h2, "illegal_0111");

    exec(0, ALU_ADD, 64'd3, 64'd4, "add_before_reset");
    op = ALU_DIV; a = 64'd1000; b = 64'd7; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 64'(ir64), 64'd1);
    check("midreset_out_valid", 64'(ov64), 64'd0);
    check("midreset_result", r64, 64'd0);
    check("midreset_zero", 64'(z64), 64'd1);
    check("midreset_illegal", 64'(il64), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exec(0, ALU_ADD, 64'd20, 64'd22, "add_after_reset");
    check("add_after_reset_held", r64, 64'd42);

    for (int n = 0; n < 60; n++) begin
      s32 = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 11);
      o = (idx == 11) ? 4'($urandom) : ops[idx];
      x = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) x = s32 ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      case ($urandom_range(0, 5))
        0: y = 64'd0;
        1: y = 64'hFFFF_FFFF_FFFF_FFFF;
        2: y = 64'($urandom_range(1, 15));
        default: y = {$urandom, $urandom};
      endcase
      exec(s32, o, x, y, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
